spi_xfer_ctrl: RTL and testbench

- Single-word SPI master (mode 0, MSB first) that drives the shared SCLK/MOSI lines and produces the active-high chip-select plus 2-bit device select.
- `cs` and `sel_out` feed the 1:4 demux directly (`cs` → demux data input, `sel_out` → demux select), which fans chip-select out to one of four converters (LTC2668 DAC, LTC2494 ADC, spares).
- Owns all transfer timing and keeps `sel_out` stable whenever `cs` can be high, so the demux never glitches a deselected device.

---
 rtl/spi_pkg.sv | 47 ++++
 rtl/spi_clk_div.sv | 40 ++++
 rtl/spi_xfer_ctrl.sv | 152 +++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI transfer controller: FSM encodings, default geometry, device map, LTC2668 commands.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    // Default transfer geometry: the 24-bit word matches the LTC2668 command/address/data frame
    localparam int SPI_WORD_BITS = 24;
    localparam int SPI_CLK_DIV   = 4;
    localparam int SPI_CS_SETUP  = 4;

    // Controller states, kept as plain constants so older tools see a simple 3-bit register
    typedef logic [2:0] spi_state_t;
    localparam spi_state_t ST_IDLE  = 3'd0;
    localparam spi_state_t ST_SETUP = 3'd1;
    localparam spi_state_t ST_SHIFT = 3'd2;
    localparam spi_state_t ST_HOLD  = 3'd3;
    localparam spi_state_t ST_GAP   = 3'd4;

    // Demux output index of each converter
    localparam logic [1:0] DEV_DAC    = 2'd0;
    localparam logic [1:0] DEV_ADC    = 2'd1;
    localparam logic [1:0] DEV_SPARE2 = 2'd2;
    localparam logic [1:0] DEV_SPARE3 = 2'd3;

    // LTC2668 command nibbles (upper nibble of the 24-bit frame)
    localparam logic [3:0] LTC2668_WRITE_N         = 4'h0;
    localparam logic [3:0] LTC2668_UPDATE_N        = 4'h1;
    localparam logic [3:0] LTC2668_WRITE_N_UPD_ALL = 4'h2;
    localparam logic [3:0] LTC2668_WRITE_UPD_N     = 4'h3;
    localparam logic [3:0] LTC2668_POWER_DOWN_N    = 4'h4;
    localparam logic [3:0] LTC2668_POWER_DOWN_CHIP = 4'h5;
    localparam logic [3:0] LTC2668_WRITE_SPAN_N    = 4'h6;
    localparam logic [3:0] LTC2668_CONFIG          = 4'h7;
    localparam logic [3:0] LTC2668_WRITE_ALL       = 4'h8;
    localparam logic [3:0] LTC2668_UPDATE_ALL      = 4'h9;
    localparam logic [3:0] LTC2668_WRITE_UPD_ALL   = 4'hA;
    localparam logic [3:0] LTC2668_MUX             = 4'hB;
    localparam logic [3:0] LTC2668_NOP             = 4'hF;

    // Build a DAC frame from command, channel address and 16-bit code
    function automatic logic [23:0] ltc2668_frame(input logic [3:0] cmd,
                                                  input logic [3:0] addr,
                                                  input logic [15:0] code);
        return {cmd, addr, code};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period tick generator: one tick every CLK_DIV enabled cycles, alternating rise/fall.
// Latency: first rise_tick CLK_DIV cycles after en goes high; ticks are combinational from internal registers.
// Backpressure: none; en low clears the phase so every enable window starts on a low half-period.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DW = $clog2(CLK_DIV + 1);

    logic [DW-1:0] div_cnt;
    logic          phase_hi;
    logic          at_end;

    assign at_end    = (div_cnt == DW'(CLK_DIV - 1));
    assign rise_tick = en & at_end & ~phase_hi;
    assign fall_tick = en & at_end &  phase_hi;

    // Count out each half-period and flip the phase at its end; idle at phase low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            phase_hi <= 1'b0;
        end else if (!en) begin
            div_cnt  <= '0;
            phase_hi <= 1'b0;
        end else if (at_end) begin
            div_cnt  <= '0;
            phase_hi <= ~phase_hi;
        end else begin
            div_cnt  <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Single-word mode-0 SPI master with registered chip-select and demux select; optional loopback via SPI_XFER_LOOPBACK_EN.
// Latency: done pulses 3*CS_SETUP + 2*CLK_DIV*WORD_BITS cycles after the accepting edge.
// Backpressure: start is honoured only in IDLE; requests while busy are dropped, not queued.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int WORD_BITS = SPI_WORD_BITS,
    parameter int CLK_DIV   = SPI_CLK_DIV,
    parameter int CS_SETUP  = SPI_CS_SETUP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           dev_sel,
    input  logic [WORD_BITS-1:0] tx_word,
    input  logic                 miso,
`ifdef SPI_XFER_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [WORD_BITS-1:0] rx_word,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 cs,
    output logic [1:0]           sel_out
);

    localparam int CW = $clog2(CS_SETUP + 1);
    localparam int BW = $clog2(WORD_BITS + 1);

    spi_state_t           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    // Holds only the bits not yet presented on mosi
    logic [WORD_BITS-2:0] tx_sr;
    logic [WORD_BITS-1:0] rx_sr;
    logic                 rx_bit;
    logic                 cnt_end;
    logic                 rise_tick;
    logic                 fall_tick;

    assign cnt_end = (cnt == CW'(CS_SETUP - 1));

`ifdef SPI_XFER_LOOPBACK_EN
    logic lb_q;
    assign rx_bit = lb_q ? mosi : miso;
`else
    assign rx_bit = miso;
`endif

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ST_SHIFT),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

`ifdef SPI_XFER_LOOPBACK_EN
    // Loopback choice is frozen at acceptance so a mid-transfer toggle cannot corrupt the word
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lb_q <= 1'b0;
        else if (state == ST_IDLE && start)
            lb_q <= loopback;
    end
`endif

    // Transfer sequencer; every pin is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_word <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs      <= 1'b0;
            sel_out <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_sr   <= tx_word[WORD_BITS-2:0];
                        mosi    <= tx_word[WORD_BITS-1];
                        sel_out <= dev_sel;
                        rx_sr   <= '0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        cs      <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (rise_tick) begin
                        sclk  <= 1'b1;
                        rx_sr <= {rx_sr[WORD_BITS-2:0], rx_bit};
                    end else if (fall_tick) begin
                        sclk <= 1'b0;
                        if (bit_cnt == BW'(WORD_BITS - 1)) begin
                            mosi    <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_HOLD;
                        end else begin
                            mosi    <= tx_sr[WORD_BITS-2];
                            tx_sr   <= {tx_sr[WORD_BITS-3:0], 1'b0};
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        cs    <= 1'b0;
                        state <= ST_GAP;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    // sel_out stays put here so the demux sees cs low before any select change
                    if (cnt_end) begin
                        cnt     <= '0;
                        rx_word <= rx_sr;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt     <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a serial slave model and expected-word scoreboard.
// Latency: checks done timing against 3*CS_SETUP + 2*CLK_DIV*WORD_BITS.
// Backpressure: exercises dropped start while busy and back-to-back held start.
module tb_spi_xfer_ctrl;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  dev_sel;
    logic [23:0] tx_word;
    logic        miso;
    logic        busy, done, sclk, mosi, cs;
    logic [23:0] rx_word;
    logic [1:0]  sel_out;

    logic        start_f;
    logic        busy_f, done_f, sclk_f, mosi_f, cs_f;
    logic [23:0] rx_word_f;
    logic [1:0]  sel_out_f;

`ifdef SPI_XFER_LOOPBACK_EN
    logic        loopback;
`endif

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_tx_q[$];
    logic [23:0] exp_rx_q[$];
    logic [1:0]  exp_sel_q[$];
    logic [23:0] miso_q[$];

    logic [23:0] miso_sr    = '0;
    logic [23:0] mon_tx     = '0;
    int          rise_cnt   = 0;
    int          done_cnt   = 0;
    int          cs_low_cnt = 0;
    logic        prev_sclk  = 1'b0;
    logic        prev_cs    = 1'b0;
    logic [1:0]  prev_sel   = 2'd0;
    logic        miso_zero  = 1'b0;

    always #5 clk = ~clk;

    assign miso = miso_zero ? 1'b0 : miso_sr[23];

    spi_xfer_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dev_sel  (dev_sel),
        .tx_word  (tx_word),
        .miso     (miso),
`ifdef SPI_XFER_LOOPBACK_EN
        .loopback (loopback),
`endif
        .busy     (busy),
        .done     (done),
        .rx_word  (rx_word),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs       (cs),
        .sel_out  (sel_out)
    );

    spi_xfer_ctrl #(.WORD_BITS(24), .CLK_DIV(1), .CS_SETUP(1)) u_fast (
        .clk      (clk),
        .rst      (rst),
        .start    (start_f),
        .dev_sel  (2'd2),
        .tx_word  (24'h000001),
        .miso     (1'b1),
`ifdef SPI_XFER_LOOPBACK_EN
        .loopback (1'b0),
`endif
        .busy     (busy_f),
        .done     (done_f),
        .rx_word  (rx_word_f),
        .sclk     (sclk_f),
        .mosi     (mosi_f),
        .cs       (cs_f),
        .sel_out  (sel_out_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model and bus monitor, sampled on the falling clock edge
    always @(negedge clk) begin
        if (rst) begin
            mon_tx     <= '0;
            rise_cnt   <= 0;
            miso_sr    <= '0;
            prev_sclk  <= 1'b0;
            prev_cs    <= 1'b0;
            prev_sel   <= 2'd0;
            cs_low_cnt <= 0;
        end else begin
            if (sel_out !== prev_sel) begin
                check("sel_change_cs_was_low", {31'd0, prev_cs}, 32'd0);
                check("sel_change_guard", {31'd0, (cs_low_cnt >= 4)}, 32'd1);
            end
            if (cs && !prev_cs) begin
                check("cs_idle_gap", {31'd0, (cs_low_cnt >= 4)}, 32'd1);
                miso_sr  <= (miso_q.size() != 0) ? miso_q.pop_front() : 24'h0;
                mon_tx   <= '0;
                rise_cnt <= 0;
            end
            if (sclk && !prev_sclk) begin
                mon_tx   <= {mon_tx[22:0], mosi};
                rise_cnt <= rise_cnt + 1;
                miso_sr  <= {miso_sr[22:0], 1'b0};
            end
            if (done === 1'b1) begin
                done_cnt <= done_cnt + 1;
                if (exp_rx_q.size() == 0) begin
                    check("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("sb_rx_word", rx_word, exp_rx_q.pop_front());
                    check("sb_mosi_stream", mon_tx, exp_tx_q.pop_front());
                    check("sb_sclk_rises", rise_cnt, 32'd24);
                    check("sb_sel_out", sel_out, exp_sel_q.pop_front());
                end
            end
            cs_low_cnt <= cs ? 0 : cs_low_cnt + 1;
            prev_sclk  <= sclk;
            prev_cs    <= cs;
            prev_sel   <= sel_out;
        end
    end

    // Issue one start pulse and queue what the transfer must produce
    task automatic launch(input logic [1:0] sel, input logic [23:0] tx,
                          input logic [23:0] pat, input logic [23:0] exp_rx);
        @(negedge clk);
        dev_sel = sel;
        tx_word = tx;
        start   = 1'b1;
        exp_tx_q.push_back(tx);
        exp_rx_q.push_back(exp_rx);
        exp_sel_q.push_back(sel);
        miso_q.push_back(pat);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Called at #1 after the accepting edge; returns the cycle index in which done is seen
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 0; n < 1000; n++) begin
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat;
        int dc;
        rst     = 1'b1;
        start   = 1'b0;
        start_f = 1'b0;
        dev_sel = 2'd0;
        tx_word = '0;
`ifdef SPI_XFER_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_cs", {31'd0, cs}, 32'd0);
        check("rst_sel_out", {30'd0, sel_out}, 32'd0);
        check("rst_rx_word", {8'd0, rx_word}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);

        // Basic transfer to the DAC with an ignored start at cycle 50
        launch(DEV_DAC, 24'h35ABCD, 24'hC3A5F0, 24'hC3A5F0);
        fork
            wait_done(lat);
            begin
                repeat (50) @(posedge clk);
                #1;
                dev_sel = 2'd3;
                tx_word = 24'h123456;
                start   = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                check("ignored_start_sel", {30'd0, sel_out}, 32'd0);
                check("ignored_start_cs", {31'd0, cs}, 32'd1);
            end
        join
        check("t1_done_cycle", lat, 32'd204);
        @(posedge clk);
        #1;
        check("t1_done_one_cycle", {31'd0, done}, 32'd0);
        check("t1_busy_cleared", {31'd0, busy}, 32'd0);
        repeat (10) @(posedge clk);

        // Back-to-back transfers from a held start
        @(negedge clk);
        dev_sel = DEV_ADC;
        tx_word = 24'hA5A5A5;
        start   = 1'b1;
        exp_tx_q.push_back(24'hA5A5A5);
        exp_rx_q.push_back(24'h3C5A0F);
        exp_sel_q.push_back(DEV_ADC);
        miso_q.push_back(24'h3C5A0F);
        @(posedge clk);
        #1;
        dev_sel = DEV_SPARE2;
        tx_word = 24'h5A5A5A;
        exp_tx_q.push_back(24'h5A5A5A);
        exp_rx_q.push_back(24'h96E187);
        exp_sel_q.push_back(DEV_SPARE2);
        miso_q.push_back(24'h96E187);
        wait_done(lat);
        check("b2b_first_done_cycle", lat, 32'd204);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_second_accepted", {31'd0, busy}, 32'd1);
        check("b2b_second_sel", {30'd0, sel_out}, 32'd2);
        wait_done(lat);
        check("b2b_second_done_cycle", lat, 32'd204);
        repeat (10) @(posedge clk);

        // Reset in the middle of SHIFT
        launch(DEV_SPARE3, 24'h0F0F0F, 24'hAAAAAA, 24'hAAAAAA);
        repeat (100) @(posedge clk);
        #1;
        check("pre_rst_cs", {31'd0, cs}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_cs", {31'd0, cs}, 32'd0);
        check("mid_rst_sclk", {31'd0, sclk}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_sel", {30'd0, sel_out}, 32'd0);
        exp_tx_q.delete();
        exp_rx_q.delete();
        exp_sel_q.delete();
        miso_q.delete();
        dc = done_cnt;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        check("rst_no_done", done_cnt, dc);
        launch(DEV_ADC, 24'h35ABCD, 24'h5AC3E1, 24'h5AC3E1);
        wait_done(lat);
        check("post_rst_done_cycle", lat, 32'd204);
        repeat (10) @(posedge clk);

        // Minimum timing instance with miso tied high
        @(negedge clk);
        start_f = 1'b1;
        @(posedge clk);
        #1;
        start_f = 1'b0;
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            if (done_f === 1'b1) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("fast_done_cycle", lat, 32'd51);
        check("fast_rx_word", {8'd0, rx_word_f}, 32'h00FFFFFF);
        check("fast_sel_out", {30'd0, sel_out_f}, 32'd2);
        repeat (10) @(posedge clk);

`ifdef SPI_XFER_LOOPBACK_EN
        // Loopback with miso forced low
        miso_zero = 1'b1;
        loopback  = 1'b1;
        launch(DEV_DAC, 24'h0F00F0, 24'h000000, 24'h0F00F0);
        loopback  = 1'b0;
        wait_done(lat);
        check("loopback_done_cycle", lat, 32'd204);
        repeat (5) @(posedge clk);
        miso_zero = 1'b0;
`endif

        repeat (5) @(posedge clk);
        check("sb_drained", exp_rx_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
